int2flt: RTL

INT2FLT -- requirements
Module: int2flt

---
 rtl/int2flt.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/int2flt.sv
// Converts a 16-bit two's-complement integer read from data memory into an
// IEEE-754 half-precision value and writes it back, one FSM step per cycle.
module int2flt #(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  output logic       busy,
  output logic [7:0] dm_addr,
  output logic       dm_wr_en,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  typedef enum logic [3:0] {
    IDLE,
    LD_HI,
    LD_LO,
    ABS,
    NORM,
    RND,
    WR_HI,
    WR_LO,
    ACK
  } state_t;

  state_t      state, state_nxt;
  logic        req_q;
  logic [7:0]  hi, lo;
  logic        sign;
  logic [15:0] mag;
  logic [4:0]  exp;
  logic [15:0] result;

  logic        start;
  logic [15:0] in_val;
  logic [15:0] abs_val;
  logic [9:0]  frac_raw;
  logic        round_up;
  logic [10:0] frac_sum;
  logic [4:0]  exp_rnd;

  assign start   = req_q & ~req;
  assign in_val  = {hi, lo};
  // Negating 0x8000 wraps to 0x8000, which is exactly the magnitude wanted.
  assign abs_val = in_val[15] ? (~in_val + 16'd1) : in_val;

  // Round to nearest even on the normalised magnitude; the hidden one is mag[15].
  assign frac_raw = mag[14:5];
  assign round_up = mag[4] & ((|mag[3:0]) | mag[5]);
  assign frac_sum = {1'b0, frac_raw} + {10'd0, round_up};
  assign exp_rnd  = exp + {4'd0, frac_sum[10]};

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = LD_HI;
      LD_HI: state_nxt = LD_LO;
      LD_LO: state_nxt = ABS;
      ABS:   state_nxt = (abs_val == 16'd0) ? WR_HI : NORM;
      NORM:  if (mag[15]) state_nxt = RND;
      RND:   state_nxt = WR_HI;
      WR_HI: state_nxt = WR_LO;
      WR_LO: state_nxt = ACK;
      ACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the state so reset forces them immediately.
  always_comb begin
    ack      = 1'b0;
    busy     = (state != IDLE);
    dm_addr  = IN_ADDR;
    dm_wr_en = 1'b0;
    dm_wdata = 8'd0;
    unique case (state)
      LD_LO: dm_addr = IN_ADDR + 8'd1;
      WR_HI: begin
        dm_addr  = OUT_ADDR;
        dm_wr_en = 1'b1;
        dm_wdata = result[15:8];
      end
      WR_LO: begin
        dm_addr  = OUT_ADDR + 8'd1;
        dm_wr_en = 1'b1;
        dm_wdata = result[7:0];
      end
      ACK:     ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= 8'd0;
      lo     <= 8'd0;
      sign   <= 1'b0;
      mag    <= 16'd0;
      exp    <= 5'd0;
      result <= 16'd0;
    end else begin
      unique case (state)
        LD_HI: hi <= dm_rdata;
        LD_LO: lo <= dm_rdata;
        ABS: begin
          sign <= in_val[15];
          mag  <= abs_val;
          exp  <= 5'd30;
          if (abs_val == 16'd0) result <= 16'd0;
        end
        NORM: begin
          if (!mag[15]) begin
            mag <= {mag[14:0], 1'b0};
            exp <= exp - 5'd1;
          end
        end
        // A fraction carry-out leaves frac_sum[9:0] at zero and bumps the exponent.
        RND:     result <= {sign, exp_rnd, frac_sum[9:0]};
        default: ;
      endcase
    end
  end

endmodule
